// File: rtl/vec_pkg.sv
// Shared constants, types and helpers for the vector memory stage.
// A vector is LANES bytes wide, and lane 0 sits in the low byte.
package vec_pkg;
   localparam int LANES     = 6;
   localparam int WIDTH     = 8;
   localparam int ADDR_W    = 8;
   localparam int MEM_DEPTH = 2 ** ADDR_W;
   localparam int CNT_W     = $clog2(LANES);

   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

   typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

   typedef enum logic [2:0] {
      IDLE,
      STORE,
      LOAD,
      LWAIT,
      DONE
   } mem_state_t;

   // Lane addresses wrap silently at the top of the byte space
   function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0]  idx);
      return base + ADDR_W'(idx);
   endfunction
endpackage

// File: rtl/vec_mem_stage_if.sv
// Request/response bundle between the EX/MEM segment and the memory stage.
// The upstream segment is the master; the memory stage is the slave.
interface vec_mem_stage_if;
   import vec_pkg::*;

   logic              MemWriteM;
   logic              MemtoRegM;
   logic [ADDR_W-1:0] AddrM;
   vec_t              WriteDataM;
   vec_t              ReadDataM;
   logic              StallM;
   logic              DoneM;

   modport master (
      output MemWriteM, MemtoRegM, AddrM, WriteDataM,
      input  ReadDataM, StallM, DoneM
   );

   modport slave (
      input  MemWriteM, MemtoRegM, AddrM, WriteDataM,
      output ReadDataM, StallM, DoneM
   );
endinterface

// File: rtl/data_mem_byte.sv
// Single-port byte RAM with synchronous write and a registered read.
// Read data for the address presented in one cycle appears in the next.
module data_mem_byte #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end
endmodule

// File: rtl/vec_mem_stage.sv
// Vector memory stage: serialises each 6-lane load or store over the byte RAM,
// stalls upstream while busy and holds the last completed load vector.
module vec_mem_stage
   import vec_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   vec_mem_stage_if.slave bus
);
   mem_state_t        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ADDR_W-1:0] addr_reg;
   vec_t              wdata_reg;
   vec_t              shadow_reg, shadow_next;
   vec_t              rdata_reg;
   logic              accept;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_wdata;
   logic [WIDTH-1:0]  mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      bus.StallM = 1'b0;
      bus.DoneM  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.MemWriteM) begin
               accept     = 1'b1;
               bus.StallM = 1'b1;
               cnt_next   = '0;
               state_next = STORE;
            end else if (bus.MemtoRegM) begin
               accept     = 1'b1;
               bus.StallM = 1'b1;
               cnt_next   = '0;
               state_next = LOAD;
            end
         end
         STORE: begin
            bus.StallM = 1'b1;
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == LAST_LANE) begin
               cnt_next   = '0;
               state_next = DONE;
            end
         end
         LOAD: begin
            bus.StallM = 1'b1;
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == LAST_LANE) begin
               cnt_next   = '0;
               state_next = LWAIT;
            end
         end
         LWAIT: begin
            bus.StallM = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            bus.DoneM  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request operands are captured once; later changes upstream are ignored
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_reg <= bus.AddrM;
      end
      if (accept && bus.MemWriteM) begin
         wdata_reg <= bus.WriteDataM;
      end
   end

   // Gating with reset keeps an interrupted store from landing one more byte
   assign mem_we    = (state_reg == STORE) && !reset;
   assign mem_addr  = lane_addr(addr_reg, cnt_reg);
   assign mem_wdata = wdata_reg[cnt_reg];

   data_mem_byte #(
      .DEPTH (MEM_DEPTH),
      .WIDTH (WIDTH),
      .AW    (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // Read data lags its address by one cycle, so lane gi lands when the counter
   // reads gi+1; the last lane arrives during LWAIT.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic cap;
      if (gi == LANES - 1) begin : g_last
         assign cap = (state_reg == LWAIT);
      end else begin : g_mid
         assign cap = (state_reg == LOAD) && (cnt_reg == CNT_W'(gi + 1));
      end
      assign shadow_next[gi] = cap ? mem_rdata : shadow_reg[gi];
   end

   always_ff @(posedge clk) begin
      shadow_reg <= shadow_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_reg <= '0;
      end else if (state_reg == LWAIT) begin
         rdata_reg <= shadow_next;
      end
   end

   assign bus.ReadDataM = rdata_reg;
endmodule

// File: tb/tb_vec_mem_stage.sv
// Directed bench for vec_mem_stage: timing, round trips, wrap, priority,
// reset abort and operand hold, with hand-computed expectations.
module tb_vec_mem_stage;
   import vec_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t rd_v;
   vec_t prev_v;
   bit   seen_done;

   vec_mem_stage_if bus ();

   vec_mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One memory op: drive the request, count stall cycles and find the DoneM cycle.
   // cont=1 starts in the current cycle (request already presented).
   task automatic run_op(input string tag, input logic wr, input logic rd,
                         input logic [7:0] a, input vec_t d, input bit cont,
                         input bit scramble, input logic after_rd, input logic [7:0] after_a,
                         input int exp_stall, input int exp_done, output vec_t rd_at_done);
      int stall_cnt;
      int done_cyc;
      if (!cont) @(negedge clk);
      bus.MemWriteM  = wr;
      bus.MemtoRegM  = rd;
      bus.AddrM      = a;
      bus.WriteDataM = d;
      stall_cnt  = 0;
      done_cyc   = 0;
      rd_at_done = '0;
      for (int c = 1; c <= 20; c++) begin
         #1;
         if (bus.StallM) stall_cnt++;
         if (bus.DoneM) begin
            done_cyc   = c;
            rd_at_done = bus.ReadDataM;
            break;
         end
         @(negedge clk);
         if (c == 1) begin
            bus.MemWriteM = 1'b0;
            bus.MemtoRegM = after_rd;
            bus.AddrM     = after_a;
         end
         if (scramble) begin
            bus.AddrM      = 8'($urandom);
            bus.WriteDataM = {16'($urandom), 32'($urandom)};
         end
      end
      $display("op %s wr=%0b rd=%0b addr=%h stall=%0d done=%0d rdata=%h",
               tag, wr, rd, a, stall_cnt, done_cyc, rd_at_done);
      check_val({tag, " stall"}, 48'(stall_cnt), 48'(exp_stall));
      check_val({tag, " done"}, 48'(done_cyc), 48'(exp_done));
   endtask

   initial begin
      reset          = 1'b1;
      bus.MemWriteM  = 1'b0;
      bus.MemtoRegM  = 1'b0;
      bus.AddrM      = '0;
      bus.WriteDataM = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      check_val("rst ReadDataM", bus.ReadDataM, 48'h0);
      check_val("rst StallM", 48'(bus.StallM), 48'h0);
      check_val("rst DoneM", 48'(bus.DoneM), 48'h0);

      // Round trip at 0x10
      run_op("st10", 1, 0, 8'h10, 48'h0F0E0D0C0B0A, 0, 0, 0, 8'h00, 7, 8, rd_v);
      check_val("st10 rdata kept", rd_v, 48'h0);
      run_op("ld10", 0, 1, 8'h10, '0, 0, 0, 0, 8'h00, 8, 9, rd_v);
      check_val("ld10 rdata", rd_v, 48'h0F0E0D0C0B0A);

      // Address wrap across 0xFF
      run_op("stFD", 1, 0, 8'hFD, 48'h050403020100, 0, 0, 0, 8'h00, 7, 8, rd_v);
      run_op("ld00", 0, 1, 8'h00, '0, 0, 0, 0, 8'h00, 8, 9, rd_v);
      check_val("ld00 lanes2..0", 48'(rd_v[23:0]), 48'h050403);
      run_op("ldFD", 0, 1, 8'hFD, '0, 0, 0, 0, 8'h00, 8, 9, rd_v);
      check_val("ldFD rdata", rd_v, 48'h050403020100);

      // Store wins over load when both are requested
      prev_v = rd_v;
      run_op("prio", 1, 1, 8'h20, 48'hAAAAAAAAAAAA, 0, 0, 0, 8'h00, 7, 8, rd_v);
      check_val("prio rdata kept", rd_v, prev_v);
      run_op("ld20", 0, 1, 8'h20, '0, 0, 0, 0, 8'h00, 8, 9, rd_v);
      check_val("ld20 rdata", rd_v, 48'hAAAAAAAAAAAA);

      // Reset in the middle of a store at 0x40 (pre-filled with zeros)
      run_op("fill40", 1, 0, 8'h40, 48'h0, 0, 0, 0, 8'h00, 7, 8, rd_v);
      @(negedge clk);
      bus.MemWriteM  = 1'b1;
      bus.AddrM      = 8'h40;
      bus.WriteDataM = 48'h112233445566;
      @(negedge clk);
      bus.MemWriteM  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      $display("op rst-mid-store addr=40 stall=%0b done=%0b rdata=%h",
               bus.StallM, bus.DoneM, bus.ReadDataM);
      check_val("abort StallM", 48'(bus.StallM), 48'h0);
      check_val("abort DoneM", 48'(bus.DoneM), 48'h0);
      check_val("abort ReadDataM", bus.ReadDataM, 48'h0);
      seen_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (bus.DoneM) seen_done = 1'b1;
      end
      check_val("abort no DoneM", 48'(seen_done), 48'h0);
      run_op("ld40", 0, 1, 8'h40, '0, 0, 0, 0, 8'h00, 8, 9, rd_v);
      check_val("ld40 partial", rd_v, 48'h000000445566);

      // Operands scrambled after acceptance must not matter
      run_op("st80", 1, 0, 8'h80, 48'hC6C5C4C3C2C1, 0, 1, 0, 8'h00, 7, 8, rd_v);
      // Load request held through a store and its DONE: accepted in the next IDLE
      run_op("st90", 1, 0, 8'h90, 48'h3C3B3A393837, 0, 0, 1, 8'h80, 7, 8, rd_v);
      @(negedge clk);
      #1;
      check_val("bubble StallM", 48'(bus.StallM), 48'h1);
      check_val("bubble DoneM", 48'(bus.DoneM), 48'h0);
      run_op("ld80", 0, 1, 8'h80, '0, 1, 0, 0, 8'h00, 8, 9, rd_v);
      check_val("ld80 rdata", rd_v, 48'hC6C5C4C3C2C1);
      run_op("ld90", 0, 1, 8'h90, '0, 0, 0, 0, 8'h00, 8, 9, rd_v);
      check_val("ld90 rdata", rd_v, 48'h3C3B3A393837);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
